// File: rtl/ifetch_unit_if.sv
// Bus bundle between the instruction fetch unit and its environment:
// instruction-memory request/response, prefetched instruction output,
// and the redirect input from the datapath.
// master: the fetch unit. slave: memory, consumer and datapath side.
interface ifetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, keeps at most one word request
// outstanding to a variable-latency instruction memory, and buffers returned
// words with their PCs in a small prefetch FIFO. A redirect flushes the FIFO
// and any in-flight response.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to flag misaligned redirect
// targets with a sticky fetch_fault that halts fetching until an aligned
// redirect. Without it the target's low two bits are ignored.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  ifetch_unit_if.master bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // IDLE: nothing outstanding; REQ: live request; FLUSH: request whose
  // response must be discarded because a redirect overtook it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  entry_t      last_q, last_d;
  entry_t      fifo_mem [FIFO_DEPTH];

  logic        ack;
  logic        push;
  logic        pop;
  logic        valid;
  logic        fault_block;
  logic        can_issue;
  logic [31:0] target_pc;
  entry_t      head;

  assign ack       = req_q & bus.imem_ack;
  assign valid     = (count_q != '0);
  assign head      = fifo_mem[rd_ptr_q];
  assign pop       = valid & bus.instr_ready & ~bus.redirect;
  assign push      = ack & (state_q == REQ) & ~bus.redirect;
  assign target_pc = {bus.redirect_pc[31:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_comb begin
    fault_d = fault_q;
    if (bus.redirect) fault_d = (bus.redirect_pc[1:0] != 2'b00);
  end

  assign fault_block     = fault_d;
  assign bus.fetch_fault = fault_q;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs  = ^bus.redirect_pc[1:0];
  assign fault_block     = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  // FIFO pointers, occupancy, fetch PC and last-delivered entry.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    if (bus.redirect) begin
      fetch_pc_d = target_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + ptr_t'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;  // wraps 0xFFFF_FFFC -> 0
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
        last_d   = head;
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // A new request fits only if the FIFO has room once it returns.
  assign can_issue = (count_d < cnt_t'(FIFO_DEPTH)) && !fault_block;

  // Request FSM: next state plus registered request valid/address.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_d;
        end
      end
      REQ, FLUSH: begin
        if (ack) begin
          // Response consumed (pushed or dropped); chain the next request.
          if (can_issue) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (bus.redirect) begin
          // Request must stay stable until acked; its data is discarded.
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  // FIFO storage write.
  // NOTE: storage has no reset; the pointers and count decide which entries
  // are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{pc: fetch_pc_q, word: bus.imem_rdata};
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? head.word : last_q.word;
  assign bus.instr_pc    = valid ? head.pc   : last_q.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit: memory responder with programmable ack
// delay, delivery monitor, and hand-computed expected PCs/words.
module tb_ifetch_unit;

  logic clk;
  logic rst;
  int   ack_delay;
  int   cyc;
  int   n_checks;
  int   n_errors;

  logic [31:0] pop_pc   [$];
  logic [31:0] pop_data [$];
  int          pop_cyc  [$];

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: every word is its address scrambled by a constant.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_log();
    pop_pc.delete();
    pop_data.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    run(2);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect    = 1'b0;
  endtask

  // Memory responder: acks after ack_delay wait cycles per request.
  initial begin
    int wait_cnt;
    wait_cnt       = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end else begin
        if (bus.imem_ack) wait_cnt = 0;  // previous request transferred
        if (wait_cnt >= ack_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = 32'hBAD0_0000;
          wait_cnt++;
        end
      end
    end
  end

  // Delivery monitor: log every word the consumer takes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        pop_pc.push_back(bus.instr_pc);
        pop_data.push_back(bus.instr);
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int hits;
    cyc             = 0;
    n_checks        = 0;
    n_errors        = 0;
    ack_delay       = 0;
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;

    // Reset state
    tick();
    check("rst_req",   bus.imem_req,    0);
    check("rst_addr",  bus.imem_addr,   32'h0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr,       32'h0);
    check("rst_pc",    bus.instr_pc,    32'h0);
    check("rst_fault", bus.fetch_fault, 0);

    // 1: streaming fetch, ready held high
    ack_delay = 0;
    bus.instr_ready = 1'b1;
    do_reset();
    run(12);
    check("t1_pc0", pop_pc[0], 32'h0);
    check("t1_pc1", pop_pc[1], 32'h4);
    check("t1_pc2", pop_pc[2], 32'h8);
    check("t1_pc3", pop_pc[3], 32'hC);
    check("t1_word1", pop_data[1], mem_word(32'h4));
    check("t1_word3", pop_data[3], mem_word(32'hC));
    check("t1_b2b", pop_cyc[3] - pop_cyc[0], 3);

    // 2: consumer stalls; FIFO fills to depth and fetching stops
    bus.instr_ready = 1'b0;
    do_reset();
    run(20);
    check("t2_req_low", bus.imem_req,    0);
    check("t2_valid",   bus.instr_valid, 1);
    check("t2_head_pc", bus.instr_pc,    32'h0);
    check("t2_head_w",  bus.instr,       mem_word(32'h0));
    check("t2_no_pop",  pop_pc.size(),   0);
    bus.instr_ready = 1'b1;
    run(12);
    check("t2_pc0", pop_pc[0], 32'h0);
    check("t2_pc1", pop_pc[1], 32'h4);
    check("t2_pc2", pop_pc[2], 32'h8);
    check("t2_pc3", pop_pc[3], 32'hC);
    check("t2_pc4", pop_pc[4], 32'h10);
    check("t2_word4", pop_data[4], mem_word(32'h10));

    // 3: redirect while request to 0x20 is outstanding
    ack_delay = 5;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.imem_req && bus.imem_addr == 32'h20) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_req20_seen", found, 1);
    run(2);
    check("t3_pre_pops", pop_pc.size(), 8);
    redirect_to(32'h100);
    check("t3_valid_after", bus.instr_valid, 0);
    check("t3_flush_req",   bus.imem_req,    1);
    check("t3_flush_addr",  bus.imem_addr,   32'h20);
    run(40);
    hits = 0;
    foreach (pop_pc[i]) if (pop_pc[i] == 32'h20) hits++;
    check("t3_no_0x20", hits, 0);
    check("t3_pc_next", pop_pc[8], 32'h100);
    check("t3_word",    pop_data[8], mem_word(32'h100));
    check("t3_pc_next2", pop_pc[9], 32'h104);

    // 4: redirect coincident with ack for 0x10
    ack_delay = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.imem_req && bus.imem_ack && bus.imem_addr == 32'h10) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_ack10_seen", found, 1);
    check("t4_pre_pops", pop_pc.size(), 4);
    redirect_to(32'h40);
    check("t4_empty", bus.instr_valid, 0);
    run(20);
    hits = 0;
    foreach (pop_pc[i]) if (pop_pc[i] == 32'h10) hits++;
    check("t4_no_0x10", hits, 0);
    check("t4_pc_next", pop_pc[4], 32'h40);

    // 5: PC wrap at top of address space
    ack_delay = 0;
    do_reset();
    run(3);
    redirect_to(32'hFFFF_FFF8);
    clear_log();
    run(10);
    check("t5_pc0", pop_pc[0], 32'hFFFF_FFF8);
    check("t5_pc1", pop_pc[1], 32'hFFFF_FFFC);
    check("t5_pc2", pop_pc[2], 32'h0000_0000);
    check("t5_w2",  pop_data[2], mem_word(32'h0));

    // 6: misaligned redirect
    do_reset();
    run(3);
    redirect_to(32'h102);
    clear_log();
`ifdef IFETCH_ALIGN_CHECK_EN
    check("t6_fault_set", bus.fetch_fault, 1);
    run(8);
    check("t6_fault_hold", bus.fetch_fault, 1);
    check("t6_no_req",     bus.imem_req,    0);
    check("t6_no_pops",    pop_pc.size(),   0);
    redirect_to(32'h200);
    check("t6_fault_clr", bus.fetch_fault, 0);
    clear_log();
    run(10);
    check("t6_pc0", pop_pc[0], 32'h200);
`else
    run(10);
    check("t6_fault_0", bus.fetch_fault, 0);
    check("t6_pc0", pop_pc[0], 32'h100);
    check("t6_pc1", pop_pc[1], 32'h104);
`endif

    // 7: asynchronous reset in the middle of a request
    ack_delay = 5;
    do_reset();
    run(2);
    check("t7_req_up", bus.imem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t7_req_drop", bus.imem_req,    0);
    check("t7_addr_rst", bus.imem_addr,   32'h0);
    check("t7_valid",    bus.instr_valid, 0);
    tick();
    rst = 1'b0;
    clear_log();
    run(20);
    check("t7_restart", pop_pc[0], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
